// File: rtl/fir_seq_controller_pkg.sv
// Shared types and register-file address helpers for the FIR sequencer.
// Address map: Disp=0, Data[i]=N-i, DataNew=N+1, Coef[k]=2N+1-k, Temp=2N+2.
package fir_seq_controller_pkg;

  typedef enum logic [2:0] {
    OpNoOp  = 3'd0,
    OpCopy  = 3'd1,
    OpLoad1 = 3'd2,
    OpLoad2 = 3'd3,
    OpAdd   = 3'd4,
    OpSub   = 3'd5,
    OpMul   = 3'd6
  } op_t;

  typedef enum logic [3:0] {
    StIdle,
    StStore,
    StZero,
    StShift,
    StMul,
    StAcc,
    StEidle,
    StLoadc,
    StWaitc
  } state_t;

  localparam int unsigned DispAddr = 0;

  function automatic int unsigned data_addr(int unsigned i, int unsigned n);
    return n - i;
  endfunction

  function automatic int unsigned coef_addr(int unsigned k, int unsigned n);
    return 2 * n + 1 - k;
  endfunction

  function automatic int unsigned new_addr(int unsigned n);
    return n + 1;
  endfunction

  function automatic int unsigned temp_addr(int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/fir_seq_controller_if.sv
// Handshake and datapath-control bundle between the FIR sequencer and the
// register file / ALU side.
interface fir_seq_controller_if #(
  parameter int unsigned ADDR_W = 4
) ();

  logic                          dr;
  logic                          lc;
  logic                          overflow;
  logic                          cnt_up;
  logic                          clear;
  logic                          modwait;
  fir_seq_controller_pkg::op_t   op;
  logic [ADDR_W-1:0]             src1;
  logic [ADDR_W-1:0]             src2;
  logic [ADDR_W-1:0]             dest;
  logic                          err;

  modport master (
    input  dr, lc, overflow,
    output cnt_up, clear, modwait, op, src1, src2, dest, err
  );

  modport slave (
    output dr, lc, overflow,
    input  cnt_up, clear, modwait, op, src1, src2, dest, err
  );

endinterface

// File: rtl/fir_seq_controller.sv
// Sequencer for an N-tap FIR datapath: sample intake, tap shift, signed MAC
// with overflow abort, and an N-step coefficient load handshake.
module fir_seq_controller
  import fir_seq_controller_pkg::*;
#(
  parameter int unsigned          NUM_TAPS  = 4,
  parameter int unsigned          ADDR_W    = 4,
  parameter logic [NUM_TAPS-1:0]  SIGN_MASK = NUM_TAPS'(4'b0101)
) (
  input logic                   clk,
  input logic                   n_reset,
  fir_seq_controller_if.master  bus
);

  localparam int unsigned         IdxW    = $clog2(NUM_TAPS);
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(NUM_TAPS - 1);

  if (2 * NUM_TAPS + 2 >= 2 ** ADDR_W) begin : g_addr_chk
    $error("ADDR_W cannot hold the Temp register address");
  end
  if ($bits(SIGN_MASK) != NUM_TAPS) begin : g_mask_chk
    $error("SIGN_MASK width must equal NUM_TAPS");
  end

  state_t            state_q, state_d;
  logic [IdxW-1:0]   tap_q, tap_d;
  logic [IdxW-1:0]   coef_q, coef_d;
  logic              modwait_q;

  int unsigned       tap_i, coef_i;
  op_t               op;
  logic [ADDR_W-1:0] src1, src2, dest;
  logic              cnt_up, clear, err;

  assign tap_i  = 32'(tap_q);
  assign coef_i = 32'(coef_q);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      coef_q    <= '0;
      modwait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      coef_q    <= coef_d;
      modwait_q <= !(state_d inside {StIdle, StEidle, StWaitc});
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    coef_d  = coef_q;
    op      = OpNoOp;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    cnt_up  = 1'b0;
    clear   = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle, StEidle: begin
        err = (state_q == StEidle);
        // Coefficient load wins over a pending sample.
        if (bus.lc) begin
          state_d = StLoadc;
          coef_d  = '0;
        end else if (bus.dr) begin
          state_d = StStore;
        end
      end
      StStore: begin
        op      = OpLoad1;
        dest    = ADDR_W'(new_addr(NUM_TAPS));
        state_d = bus.dr ? StZero : StEidle;
      end
      StZero: begin
        op      = OpSub;
        src1    = ADDR_W'(DispAddr);
        src2    = ADDR_W'(DispAddr);
        dest    = ADDR_W'(DispAddr);
        cnt_up  = 1'b1;
        tap_d   = LastIdx;
        state_d = StShift;
      end
      StShift: begin
        op   = OpCopy;
        dest = ADDR_W'(data_addr(tap_i, NUM_TAPS));
        src1 = (tap_q == '0) ? ADDR_W'(new_addr(NUM_TAPS))
                             : ADDR_W'(data_addr(tap_i - 1, NUM_TAPS));
        if (tap_q == '0) begin
          tap_d   = LastIdx;
          state_d = StMul;
        end else begin
          tap_d = tap_q - 1'b1;
        end
      end
      StMul: begin
        op      = OpMul;
        dest    = ADDR_W'(temp_addr(NUM_TAPS));
        src1    = ADDR_W'(data_addr(tap_i, NUM_TAPS));
        src2    = ADDR_W'(coef_addr(tap_i, NUM_TAPS));
        state_d = StAcc;
      end
      StAcc: begin
        op   = SIGN_MASK[tap_q] ? OpSub : OpAdd;
        dest = ADDR_W'(DispAddr);
        src1 = ADDR_W'(DispAddr);
        src2 = ADDR_W'(temp_addr(NUM_TAPS));
        if (bus.overflow) begin
          state_d = StEidle;
        end else if (tap_q == '0) begin
          state_d = StIdle;
        end else begin
          tap_d   = tap_q - 1'b1;
          state_d = StMul;
        end
      end
      StLoadc: begin
        op    = OpLoad2;
        dest  = ADDR_W'(coef_addr(coef_i, NUM_TAPS));
        clear = (coef_q == '0);
        if (!bus.lc) begin
          if (coef_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            coef_d  = coef_q + 1'b1;
            state_d = StWaitc;
          end
        end
      end
      StWaitc: begin
        if (bus.lc) state_d = StLoadc;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.op      = op;
  assign bus.src1    = src1;
  assign bus.src2    = src2;
  assign bus.dest    = dest;
  assign bus.cnt_up  = cnt_up;
  assign bus.clear   = clear;
  assign bus.err     = err;
  assign bus.modwait = modwait_q;

endmodule
